// File: rtl/rv_word_packer_if.sv
// Ready/valid bundle for rv_word_packer: narrow word stream in, packed wide beats out.
// master drives words and consumes beats; slave is the packer itself.
interface rv_word_packer_if #(
   parameter int DW = 32,
   parameter int N  = 4
);
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_data;
   logic            in_last;
   logic            out_valid;
   logic            out_ready;
   logic [N*DW-1:0] out_data;
   logic [N-1:0]    out_keep;
   logic            out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );
endinterface

// File: rtl/rv_word_packer.sv
// Packs N consecutive DW-bit words into one registered N*DW-bit beat;
// in_last closes a group early with a contiguous lane-valid mask.

module rv_word_packer_lane #(
   parameter int DW = 32
) (
   input  logic          sel,
   input  logic [DW-1:0] in_data,
   input  logic [DW-1:0] acc,
   input  logic          acc_keep,
   output logic [DW-1:0] word,
   output logic          keep
);
   assign word = sel ? in_data : acc;
   assign keep = sel | acc_keep;
endmodule

module rv_word_packer #(
   parameter int DW = 32,
   parameter int N  = 4
) (
   input logic            clk,
   input logic            rst,
   rv_word_packer_if.slave bus
);
   localparam int            CW        = $clog2(N);
   localparam logic [CW-1:0] LAST_LANE = CW'(N - 1);

   logic [CW-1:0]        cnt;
   logic [N-1:0][DW-1:0] acc;
   logic [N-1:0][DW-1:0] beat;
   logic [N-1:0][DW-1:0] out_data;
   logic [N-1:0]         acc_keep;
   logic [N-1:0]         beat_keep;
   logic [N-1:0]         out_keep;
   logic                 out_valid;
   logic                 out_last;
   logic                 push;
   logic                 pop;
   logic                 done;

   // Any stalled beat blocks all input, even words that would not complete a group.
   assign bus.in_ready = ~rst & (~out_valid | bus.out_ready);
   assign push         = bus.in_valid & bus.in_ready;
   assign pop          = out_valid & bus.out_ready;
   assign done         = (cnt == LAST_LANE) | bus.in_last;

   for (genvar k = 0; k < N; k++) begin : g_lane
      rv_word_packer_lane #(.DW(DW)) u_lane (
         .sel      (cnt == CW'(k)),
         .in_data  (bus.in_data),
         .acc      (acc[k]),
         .acc_keep (acc_keep[k]),
         .word     (beat[k]),
         .keep     (beat_keep[k])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         acc       <= '0;
         acc_keep  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
      end else if (push && done) begin
         // A completing push implies the output slot is empty or popping now.
         out_data  <= beat;
         out_keep  <= beat_keep;
         out_last  <= bus.in_last;
         out_valid <= 1'b1;
         cnt       <= '0;
         acc       <= '0;
         acc_keep  <= '0;
      end else begin
         if (push) begin
            acc[cnt]      <= bus.in_data;
            acc_keep[cnt] <= 1'b1;
            cnt           <= cnt + 1'b1;
         end
         if (pop) out_valid <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
   assign bus.out_keep  = out_keep;
   assign bus.out_last  = out_last;
endmodule

// File: doc/rv_word_packer.md
# rv_word_packer

Downstream consumer of the one-deep ready/valid buffer: accepts a stream of DW-bit words and packs N consecutive words into one N*DW-bit beat on a registered ready/valid output. An `in_last` marker closes a group early and emits a partial beat with a lane-valid mask, so packet boundaries survive the width change. Used between narrow producers and wide sinks (bus write ports, wide FIFOs).

## Interface
- `DW`, default 32: input word width in bits (≥1).
- `N`, default 4: words per output beat (≥2); lane counter width is clog2(N).
- `clk`  in  1  rising-edge clock, sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  packer accepts a word this cycle.
- `in_data`  in  DW  input word.
- `in_last`  in  1  word is the last of its packet; qualified by `in_valid`.
- `out_valid`  out  1  packed beat available.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  N*DW  packed beat; lane k = bits [k*DW +: DW].
- `out_keep`  out  N  lane-valid mask, contiguous from lane 0.
- `out_last`  out  1  beat closes a packet.

## Operation
- Handshakes: push = `in_valid & in_ready`, pop = `out_valid & out_ready`. Data moves only on these events.
- `in_ready = ~rst & (~out_valid | out_ready)`. It is combinational and does not depend on `in_valid`, `in_data` or `in_last`.
- State:
  - lane counter `cnt` (0..N-1);
  - accumulator `acc` (N*DW) with mask `acc_keep` (N);
  - output register holding `out_data`, `out_keep`, `out_last`, `out_valid`.
- Push, not completing (`cnt < N-1` and `in_last=0`): write `in_data` into `acc` lane `cnt`, set `acc_keep[cnt]`, increment `cnt`.
- Push, completing (`cnt == N-1` or `in_last=1`): load the output register with `acc` merged with `in_data` at lane `cnt`.
  - `out_keep` = `acc_keep` with bit `cnt` set.
  - `out_last` = `in_last`.
  - `out_valid` ← 1.
  - Clear `acc`, `acc_keep` and `cnt` to 0.
- Lanes not written in a partial beat are driven 0 in `out_data`; their `out_keep` bits are 0.
- Full group ending exactly on `in_last` (`cnt == N-1`, `in_last=1`): `out_keep` is all ones and `out_last` is 1.
- Pop without a completing push: `out_valid` ← 0. `out_data`, `out_keep` and `out_last` keep their values but are meaningless.
- Pop with a completing push in the same cycle: the output register reloads with the new beat and `out_valid` stays 1, giving zero bubble.
- No pop and no completing push: the output register holds.
- Reset (any cycle, including mid-group or with a beat pending):
  - `cnt`, `acc`, `acc_keep` → 0;
  - `out_valid`, `out_last` → 0; `out_data`, `out_keep` → 0;
  - a partial group or a pending beat is discarded;
  - `in_ready` is 0 during the reset cycle and 1 in the first cycle after reset.

## Timing
- Latency: the completing word pushed at edge t produces `out_valid=1` with its beat from edge t+1.
- Throughput: 1 word/cycle sustained while `out_ready=1`, i.e. one full beat every N cycles.
- Backpressure: while `out_valid=1` and `out_ready=0`, `in_ready=0`. This stalls even non-completing words, which is deliberate and keeps the path simple.
- Stability: while `out_valid=1` and `out_ready=0`, `out_data`, `out_keep` and `out_last` are held constant.
- No combinational path from `in_valid`/`in_data`/`in_last` to any output. The only combinational path to `in_ready` is from `out_ready` (and `rst`).
- Reset values: `in_ready` 0 during reset, `out_valid` 0, `out_data` 0, `out_keep` 0, `out_last` 0.

## Test plan
- Full group: DW=32, N=4. Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `in_last=0` and `out_ready=1`.
  - One cycle after the 4th push: `out_valid=1`, `out_data=0x00000044_00000033_00000022_00000011`, `out_keep=4'b1111`, `out_last=0`.
- Partial group: push 0xA, then 0xB with `in_last=1`.
  - Beat: `out_data=0x0..0_0000000B_0000000A`, `out_keep=4'b0011`, `out_last=1`.
  - The next group starts at lane 0.
- Backpressure: complete a beat with `out_ready=0` held for 5 cycles.
  - `in_ready=0` for all 5 cycles and the outputs are constant.
  - On release, the pop occurs and `in_ready` rises in the same cycle.
- Back-to-back: 12 words streamed continuously with `out_ready=1`.
  - Exactly 3 beats, in order.
  - No stall cycle on `in_ready`, including the cycle where a completing push coincides with a pop.
- Reset mid-group, in two variants:
  - Push 2 words, assert `rst` for 1 cycle, then push 4 words. Only the second group appears, with `out_keep=4'b1111`.
  - Assert `rst` while a beat is pending and `out_ready=0`. `out_valid` drops to 0 and the beat is never emitted.
- Single-word packet: `in_last=1` at `cnt=0`.
  - `out_keep=4'b0001`, `out_last=1`, and lanes 1–3 of `out_data` are zero.
